// File: rtl/pipeline_dump_tx_pkg.sv
// Shared debug-frame constants for the pipeline dump transmitter.
package pipeline_dump_tx_pkg;

  localparam logic [7:0]  HEADER     = 8'hA5;
  localparam int unsigned FRAME_LEN  = 50;

  // Frame byte offsets of each field
  localparam int unsigned OFF_PC     = 1;
  localparam int unsigned OFF_IF_ID  = 5;
  localparam int unsigned OFF_ID_EX  = 13;
  localparam int unsigned OFF_EX_MEM = 30;
  localparam int unsigned OFF_MEM_WB = 40;
  localparam int unsigned OFF_CSUM   = 49;

  // Padded field widths in bits, derived from the offsets
  localparam int unsigned PC_W     = (OFF_IF_ID  - OFF_PC)     * 8;
  localparam int unsigned IF_ID_W  = (OFF_ID_EX  - OFF_IF_ID)  * 8;
  localparam int unsigned ID_EX_W  = (OFF_EX_MEM - OFF_ID_EX)  * 8;
  localparam int unsigned EX_MEM_W = (OFF_MEM_WB - OFF_EX_MEM) * 8;
  localparam int unsigned MEM_WB_W = (OFF_CSUM   - OFF_MEM_WB) * 8;

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_dump_tx.sv
// Snapshots the pipeline latches on request and pushes them as a 50-byte
// checksummed frame into a UART TX FIFO, honouring FIFO-full backpressure.
module pipeline_dump_tx
  import pipeline_dump_tx_pkg::*;
#(
  parameter int unsigned SIZE        = 32,
  parameter int unsigned IF_ID_SIZE  = 64,
  parameter int unsigned ID_EX_SIZE  = 129,
  parameter int unsigned EX_MEM_SIZE = 78,
  parameter int unsigned MEM_WB_SIZE = 72
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [SIZE-1:0]        i_pc,
  input  logic [IF_ID_SIZE-1:0]  i_IF_ID,
  input  logic [ID_EX_SIZE-1:0]  i_ID_EX,
  input  logic [EX_MEM_SIZE-1:0] i_EX_MEM,
  input  logic [MEM_WB_SIZE-1:0] i_MEM_WB,
  input  logic                   i_tx_full,
  output logic                   o_tx_start,
  output logic [7:0]             o_tx_data,
  output logic                   o_busy,
  output logic                   o_done
);

  state_t                r_state;
  state_t                w_next;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_csum;
  // Byte-addressed by frame index; slot 0 is the header position and stays zero
  logic [OFF_CSUM-1:0][7:0] r_snap;

  logic                  w_push;
  logic                  w_capture;
  logic [7:0]            w_byte;

  logic [PC_W-1:0]       w_pc_pad;
  logic [IF_ID_W-1:0]    w_if_id_pad;
  logic [ID_EX_W-1:0]    w_id_ex_pad;
  logic [EX_MEM_W-1:0]   w_ex_mem_pad;
  logic [MEM_WB_W-1:0]   w_mem_wb_pad;

  assign w_pc_pad     = PC_W'(i_pc);
  assign w_if_id_pad  = IF_ID_W'(i_IF_ID);
  assign w_id_ex_pad  = ID_EX_W'(i_ID_EX);
  assign w_ex_mem_pad = EX_MEM_W'(i_EX_MEM);
  assign w_mem_wb_pad = MEM_WB_W'(i_MEM_WB);

  assign w_capture = (r_state == ST_IDLE) && i_start;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake decode
  always_comb begin
    w_next     = r_state;
    w_push     = 1'b0;
    o_tx_start = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_SEND;
      end
      ST_SEND: begin
        o_busy     = 1'b1;
        w_push     = !i_tx_full;
        o_tx_start = w_push;
        if (w_push && (r_idx == IDX_W'(OFF_CSUM))) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Byte selection: header and checksum are generated, fields come from the snapshot
  always_comb begin
    w_byte = r_snap[r_idx];
    if (r_idx == '0)                      w_byte = HEADER;
    else if (r_idx == IDX_W'(OFF_CSUM))   w_byte = r_csum;
    o_tx_data = (r_state == ST_SEND) ? w_byte : '0;
  end

  // Snapshot capture on an accepted start
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_snap <= '0;
    else if (w_capture)
      r_snap <= {w_mem_wb_pad, w_ex_mem_pad, w_id_ex_pad, w_if_id_pad, w_pc_pad, 8'h00};
  end

  // Byte index and running checksum advance only on pushed bytes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx  <= '0;
      r_csum <= '0;
    end else if (w_capture) begin
      r_idx  <= '0;
      r_csum <= '0;
    end else if (w_push) begin
      r_idx  <= r_idx + 1'b1;
      r_csum <= r_csum ^ w_byte;
    end
  end

endmodule

// File: tb/tb_pipeline_dump_tx.sv
module tb_pipeline_dump_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  pc;
  logic [63:0]  ifid;
  logic [128:0] idex;
  logic [77:0]  exmem;
  logic [71:0]  memwb;
  logic         full;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         busy;
  logic         done;

  int unsigned  checks = 0;
  int unsigned  errors = 0;

  logic [7:0]   exp_frame [50];
  logic [7:0]   got [$];

  pipeline_dump_tx #(
    .SIZE(32), .IF_ID_SIZE(64), .ID_EX_SIZE(129), .EX_MEM_SIZE(78), .MEM_WB_SIZE(72)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pc(pc),
    .i_IF_ID(ifid), .i_ID_EX(idex), .i_EX_MEM(exmem), .i_MEM_WB(memwb),
    .i_tx_full(full), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as the byte list the protocol describes: header, LSB-first fields, XOR checksum
  task automatic model;
    logic [7:0] x;
    int unsigned k;
    logic [135:0] ie;
    logic [79:0]  em;
    ie = 136'(idex);
    em = 80'(exmem);
    k = 0;
    exp_frame[k++] = 8'hA5;
    for (int i = 0; i < 4;  i++) exp_frame[k++] = 8'(pc    >> (8 * i));
    for (int i = 0; i < 8;  i++) exp_frame[k++] = 8'(ifid  >> (8 * i));
    for (int i = 0; i < 17; i++) exp_frame[k++] = 8'(ie    >> (8 * i));
    for (int i = 0; i < 10; i++) exp_frame[k++] = 8'(em    >> (8 * i));
    for (int i = 0; i < 9;  i++) exp_frame[k++] = 8'(memwb >> (8 * i));
    x = 8'h00;
    for (int i = 0; i < 49; i++) x = x ^ exp_frame[i];
    exp_frame[49] = x;
  endtask

  task automatic randomize_inputs;
    pc    = $urandom();
    ifid  = {$urandom(), $urandom()};
    idex  = 129'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    exmem = 78'({$urandom(), $urandom(), $urandom()});
    memwb = 72'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic run_frame(input int unsigned stall_at, input int unsigned stall_len,
                           input bit disturb, input bit abort, input bit rand_full);
    int unsigned stall_left;
    int unsigned cyc;
    int unsigned extra;
    bit fin;
    stall_left = stall_len;
    cyc = 0;
    fin = 1'b0;
    got.delete();
    model();
    start = 1'b1;
    step();
    start = 1'b0;
    while (!fin && cyc < 400) begin
      full = 1'b0;
      if (got.size() == stall_at && stall_left > 0) begin
        full = 1'b1;
        stall_left--;
      end else if (rand_full && $urandom_range(3) == 0) begin
        full = 1'b1;
      end
      if (disturb && cyc == 5) begin start = 1'b1; pc = $urandom(); end
      if (disturb && cyc == 6) start = 1'b0;
      #1;
      if (abort && got.size() == 21) begin
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_tx_start", 64'(tx_start), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_data", 64'(tx_data), 64'd0);
        step(); step();
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
          step();
          if (tx_start || busy) extra++;
        end
        check("abort_quiet", 64'(extra), 64'd0);
        fin = 1'b1;
      end else if (done) begin
        check("done_len", 64'(got.size()), 64'd50);
        check("done_busy", 64'(busy), 64'd1);
        check("done_no_push", 64'(tx_start), 64'd0);
        if (stall_len == 0 && !rand_full && !disturb) check("done_latency", 64'(cyc), 64'd50);
        fin = 1'b1;
      end else begin
        check("send_busy", 64'(busy), 64'd1);
        check("send_push", 64'(tx_start), 64'(!full));
        if (tx_start) got.push_back(tx_data);
      end
      if (!fin) begin
        step();
        cyc++;
      end
    end
    if (!fin) check("timeout", 64'(cyc), 64'd0);
    if (!abort) begin
      step();
      check("post_done", 64'(done), 64'd0);
      check("post_busy", 64'(busy), 64'd0);
      check("post_data", 64'(tx_data), 64'd0);
      check("frame_len", 64'(got.size()), 64'd50);
      for (int i = 0; i < 50; i++)
        if (i < got.size()) check($sformatf("byte%0d", i), 64'(got[i]), 64'(exp_frame[i]));
      if (disturb) begin
        extra = 0;
        for (int i = 0; i < 60; i++) begin
          if (tx_start || busy) extra++;
          step();
        end
        check("no_second_frame", 64'(extra), 64'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; full = 1'b0;
    pc = '0; ifid = '0; idex = '0; exmem = '0; memwb = '0;
    step(); step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(tx_data), 64'd0);
    rst = 1'b0;
    step();

    // All-zero frame
    run_frame(99, 0, 1'b0, 1'b0, 1'b0);
    check("zero_csum", 64'(got[49]), 64'hA5);

    // PC only
    pc = 32'h12345678;
    run_frame(99, 0, 1'b0, 1'b0, 1'b0);
    check("pc_b1", 64'(got[1]), 64'h78);
    check("pc_b2", 64'(got[2]), 64'h56);
    check("pc_b3", 64'(got[3]), 64'h34);
    check("pc_b4", 64'(got[4]), 64'h12);
    check("pc_csum", 64'(got[49]), 64'hAD);

    // ID/EX all ones, padding to 136 bits
    pc = '0;
    idex = '1;
    run_frame(99, 0, 1'b0, 1'b0, 1'b0);
    check("idex_b28", 64'(got[28]), 64'hFF);
    check("idex_b29", 64'(got[29]), 64'h01);
    check("idex_b30", 64'(got[30]), 64'h00);
    check("idex_csum", 64'(got[49]), 64'hA4);

    // Backpressure: FIFO full for 10 cycles after byte 3
    randomize_inputs();
    run_frame(4, 10, 1'b0, 1'b0, 1'b0);

    // Start re-pulse and PC change mid-frame
    randomize_inputs();
    run_frame(99, 0, 1'b1, 1'b0, 1'b0);

    // Reset after byte 20, then a fresh frame
    randomize_inputs();
    run_frame(99, 0, 1'b0, 1'b1, 1'b0);
    randomize_inputs();
    run_frame(99, 0, 1'b0, 1'b0, 1'b0);
    check("fresh_header", 64'(got[0]), 64'hA5);

    // Random data with random backpressure
    for (int n = 0; n < 3; n++) begin
      randomize_inputs();
      run_frame(99, 0, 1'b0, 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
